spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- SPI target (slave) that plays the flash side of the serial-flash link driven by the team's SPI master.
- Oversamples SCLK/CS/MOSI on the system clock and decodes an 8-bit command plus a 24-bit address header.
- Sends write-data bytes to a user-side write strobe, fetches read-data bytes through a user read request and shifts them out on MISO.
- Used as a flash stand-in for loopback and bring-up, and as the target end of a board-to-board SPI link.

Parameters:
- P_ADDR_WIDTH, 24: address field width in the header (header = 8 + P_ADDR_WIDTH bits).
- P_PAGE_BITS, 8: low address bits that wrap during a write burst (256-byte page).
- P_CMD_WRITE, 8'h02: page-program command.
- P_CMD_READ, 8'h03: read command.
- P_CMD_RDSR, 8'h05: read-status command (no address phase).

Ports:
- i_clk  in  1  system clock; must be ≥8× SCLK.
- i_rst_n  in  1  asynchronous active-low reset.
- i_spi_clk  in  1  SCLK from master; mode 0 or 3.
- i_spi_cs  in  1  chip select, active low.
- i_spi_mosi  in  1  master-out data, MSB first.
- o_spi_miso  out  1  target-out data.
- o_spi_miso_oe  out  1  MISO drive enable.
- o_cmd  out  8  last decoded command.
- o_cmd_valid  out  1  1-cycle pulse when o_cmd is updated.
- o_addr  out  P_ADDR_WIDTH  address for the current o_wr_valid or o_rd_req.
- o_wr_data  out  8  received write byte.
- o_wr_valid  out  1  1-cycle write strobe.
- o_rd_req  out  1  1-cycle read-fetch strobe.
- i_rd_data  in  8  read byte; valid exactly 1 cycle after o_rd_req.
- i_status  in  8  status byte returned for RDSR.
- o_busy  out  1  synchronized CS asserted.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and all shift registers and counters are cleared.
- Input synchronization:
  - i_spi_clk, i_spi_cs and i_spi_mosi each pass through a 2-FF synchronizer.
  - SCLK rise and fall are edge-detected on the synchronized copy.
  - Latency from pin to action is 3 i_clk cycles.
- Bit timing: MOSI is sampled on each SCLK rise. MISO shifts on each SCLK fall. Bits are MSB first.
- FSM states and transitions:
  - IDLE: go to CMD when synchronized CS falls.
  - CMD: after 8 rises, latch o_cmd and pulse o_cmd_valid on the next cycle. Then:
    - WRITE or READ → ADDR.
    - RDSR → STAT.
    - any other command → IGNORE.
  - ADDR: after P_ADDR_WIDTH rises, load the address counter. WRITE → WDATA; READ → RDATA.
  - WDATA:
    - After every 8 rises, pulse o_wr_valid for 1 cycle with o_wr_data and o_addr = current address.
    - Then increment the address: only the low P_PAGE_BITS bits count, wrapping 0xFF→0x00; the upper bits are unchanged.
  - RDATA:
    - The address phase completing, and every later byte boundary (8 rises), issues o_rd_req with o_addr = fetch address.
    - On the next cycle, i_rd_data loads the TX shift register; the fetch address then increments over the full width (0xFFFFFF→0x000000).
    - The MSB drives MISO at the next SCLK fall.
    - A prefetch for a byte that is never clocked out is permitted; read is side-effect free.
  - STAT: i_status is captured at CMD completion and at every byte boundary, and shifted out. It repeats until CS rises.
  - IGNORE: ignores MOSI, leaves MISO undriven, waits for CS to rise.
- Any state: CS rising → IDLE within 3 cycles.
  - A partial byte is discarded: no o_wr_valid, no further o_rd_req.
  - A partial header produces no o_cmd_valid.
- o_spi_miso_oe = 1 only in RDATA/STAT while CS is low. o_spi_miso = 0 when not enabled.
- o_busy follows synchronized CS (inverted) with no extra delay.
- Simultaneous events: CS rise and a byte-complete rise in the same cycle → CS wins; the byte is dropped.
- Reset asserted mid-transaction → immediate IDLE, no strobes. The next transaction needs a fresh CS fall.
- CS held low at reset release → remain in IDLE until CS goes high and then low again.

Optional Feature:
- Macro: SPI_RESP_WREN_EN
- Defined:
  - Write-enable latch WEL is set by command 8'h06 and cleared by 8'h04.
  - WEL is also cleared on the CS rise that ends any WRITE transaction.
  - A WRITE with WEL=0 goes to IGNORE after the header (no o_wr_valid).
  - RDSR returns {i_status[7:2], WEL, i_status[0]}.
- Not defined:
  - WRITE is always accepted.
  - 8'h06/8'h04 decode as unknown commands (o_cmd_valid pulses, then IGNORE).
  - RDSR returns i_status unchanged.

Test Plan:
- Write burst: CS low, send 02 00 12 FE AA 55, CS high → o_cmd_valid with o_cmd=02; o_wr_valid twice: (addr 0x0012FE, data AA), then (0x0012FF, 55).
- Page wrap: 02 00 12 FF 11 22 33 → writes at 0x0012FF, 0x001200, 0x001201.
- Read: 03 00 00 10 followed by 16 clocks, with bench i_rd_data = addr[7:0]^8'h5A → MISO bytes 4A, 4B; o_rd_req at 0x000010, 0x000011 (0x000012 prefetch allowed); o_spi_miso_oe high only during the data phase.
- Status: 05 followed by 16 clocks, i_status=8'h81 → MISO 81 81; no address phase, no o_rd_req.
- Abort: 02 00 00 00, 5 data bits, CS high → no o_wr_valid; FSM back in IDLE; a following full write behaves normally.
- Unknown command / WREN: 9F → o_cmd_valid with 9F, no strobes, MISO undriven. With SPI_RESP_WREN_EN defined: 02 … without a prior 06 → no writes; 06, then 02 00 00 00 A5 → one write; a second 02 without 06 → no writes.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// ---------------------------------------------------------------------------
// spi_flash_responder_if
//   Groups the SPI pins and the user-side command/data bus of the flash
//   responder.
//   slave  : view of the responder (drives MISO, strobes, address, busy)
//   master : view of the SPI master plus user logic (drives SCLK/CS/MOSI,
//            read data and status)
//   Members:
//     i_spi_clk, i_spi_cs, i_spi_mosi   SPI pins into the responder
//     o_spi_miso, o_spi_miso_oe         SPI data out and its drive enable
//     o_cmd, o_cmd_valid                decoded command and update pulse
//     o_addr                            address for o_wr_valid / o_rd_req
//     o_wr_data, o_wr_valid             received write byte and strobe
//     o_rd_req, i_rd_data               read fetch strobe, data 1 cycle later
//     i_status                          status byte for RDSR
//     o_busy                            synchronized chip select asserted
// ---------------------------------------------------------------------------
interface spi_flash_responder_if #(
   parameter int P_ADDR_WIDTH = 24
);
   logic                    i_spi_clk;
   logic                    i_spi_cs;
   logic                    i_spi_mosi;
   logic                    o_spi_miso;
   logic                    o_spi_miso_oe;
   logic [7:0]              o_cmd;
   logic                    o_cmd_valid;
   logic [P_ADDR_WIDTH-1:0] o_addr;
   logic [7:0]              o_wr_data;
   logic                    o_wr_valid;
   logic                    o_rd_req;
   logic [7:0]              i_rd_data;
   logic [7:0]              i_status;
   logic                    o_busy;

   modport slave (
      input  i_spi_clk, i_spi_cs, i_spi_mosi, i_rd_data, i_status,
      output o_spi_miso, o_spi_miso_oe, o_cmd, o_cmd_valid, o_addr,
             o_wr_data, o_wr_valid, o_rd_req, o_busy
   );

   modport master (
      output i_spi_clk, i_spi_cs, i_spi_mosi, i_rd_data, i_status,
      input  o_spi_miso, o_spi_miso_oe, o_cmd, o_cmd_valid, o_addr,
             o_wr_data, o_wr_valid, o_rd_req, o_busy
   );
endinterface

// File: rtl/spi_flash_responder.sv
// ---------------------------------------------------------------------------
// spi_flash_responder
//   SPI target that behaves like the flash side of a serial-flash link.
//   SCLK/CS/MOSI are oversampled on i_clk (must be >= 8x SCLK), an 8-bit
//   command and an address header are decoded, write bytes are handed to a
//   write strobe, read bytes are fetched through a read request and shifted
//   out on MISO, and RDSR returns a status byte repeatedly.
//   Ports:
//     i_clk    system clock
//     i_rst_n  asynchronous active-low reset
//     bus      spi_flash_responder_if.slave (SPI pins + user bus)
//   Optional feature (macro SPI_RESP_WREN_EN):
//     write-enable latch set by 8'h06, cleared by 8'h04 and at the end of
//     every WRITE transaction; WRITE without it is ignored after the header;
//     RDSR reports it in bit 1.
// ---------------------------------------------------------------------------
module spi_flash_responder #(
   parameter int         P_ADDR_WIDTH = 24,
   parameter int         P_PAGE_BITS  = 8,
   parameter logic [7:0] P_CMD_WRITE  = 8'h02,
   parameter logic [7:0] P_CMD_READ   = 8'h03,
   parameter logic [7:0] P_CMD_RDSR   = 8'h05
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   spi_flash_responder_if.slave bus
);
   localparam int CW = $clog2(P_ADDR_WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BYTE_BIT = CW'(7);
   localparam logic [CW-1:0] LAST_ADDR_BIT = CW'(P_ADDR_WIDTH - 1);
   localparam logic [P_ADDR_WIDTH-1:0] PAGE_MASK =
      P_ADDR_WIDTH'((1 << P_PAGE_BITS) - 1);
`ifdef SPI_RESP_WREN_EN
   localparam logic [7:0] CMD_WREN = 8'h06;
   localparam logic [7:0] CMD_WRDI = 8'h04;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_STAT, S_IGNORE
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchronizers, bit order {sclk, cs, mosi}. CS resets high so the
   // bus reads as deselected (o_busy = 0) while the chain fills.
   // ---------------------------------------------------------------------
   logic [2:0] sync_meta_q;
   logic [2:0] sync_q;
   logic       sclk_prev_q;
   logic [1:0] sync_ok_q;   // sync_q[1] holds a real pin sample once set

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_meta_q <= 3'b010;
         sync_q      <= 3'b010;
         sclk_prev_q <= 1'b0;
         sync_ok_q   <= 2'b00;
      end else begin
         sync_meta_q <= {bus.i_spi_clk, bus.i_spi_cs, bus.i_spi_mosi};
         sync_q      <= sync_meta_q;
         sclk_prev_q <= sync_q[2];
         sync_ok_q   <= {sync_ok_q[0], 1'b1};
      end
   end

   logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
   assign sclk_s    = sync_q[2];
   assign cs_s      = sync_q[1];
   assign mosi_s    = sync_q[0];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;

   // ---------------------------------------------------------------------
   // Main FSM and datapath
   // ---------------------------------------------------------------------
   state_t                  state_q;
   logic                    armed_q;     // CS seen high since reset / last txn
   logic [CW-1:0]           bit_cnt_q;
   logic [P_ADDR_WIDTH-1:0] shift_q;
   logic [P_ADDR_WIDTH-1:0] shift_d;
   logic [7:0]              cmd_q;
   logic                    cmd_valid_q;
   logic [P_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]              wr_data_q;
   logic                    wr_valid_q;
   logic                    rd_req_q;
   logic                    rd_cap_q;    // i_rd_data is valid this cycle
   logic [7:0]              tx_q;
   logic                    miso_q;
   logic                    miso_oe_q;
   logic [7:0]              status_byte;
   logic [P_ADDR_WIDTH-1:0] page_inc;
`ifdef SPI_RESP_WREN_EN
   logic                    wel_q;
   logic                    wr_txn_q;    // current transaction is a WRITE
`endif

   assign shift_d  = {shift_q[P_ADDR_WIDTH-2:0], mosi_s};
   // Only the in-page bits advance during a write burst.
   assign page_inc = (addr_q & ~PAGE_MASK) | ((addr_q + 1'b1) & PAGE_MASK);

`ifdef SPI_RESP_WREN_EN
   assign status_byte = {bus.i_status[7:2], wel_q, bus.i_status[0]};
`else
   assign status_byte = bus.i_status;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         wr_valid_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         rd_cap_q    <= 1'b0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
`ifdef SPI_RESP_WREN_EN
         wel_q       <= 1'b0;
         wr_txn_q    <= 1'b0;
`endif
      end else begin
         cmd_valid_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         rd_cap_q    <= rd_req_q;

         if (miso_oe_q && sclk_fall) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
         end
         // Fetched byte lands one cycle after the request; the fetch
         // address then advances over the full width.
         if (rd_cap_q) begin
            tx_q   <= bus.i_rd_data;
            addr_q <= addr_q + 1'b1;
         end
         if (wr_valid_q) begin
            addr_q <= page_inc;
         end

         // CS release wins over any byte completing in the same cycle.
         if (state_q != S_IDLE && cs_s) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
`ifdef SPI_RESP_WREN_EN
            if (wr_txn_q) begin
               wel_q <= 1'b0;
            end
            wr_txn_q  <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (sync_ok_q[1] && cs_s) begin
                     armed_q <= 1'b1;
                  end
                  if (armed_q && !cs_s) begin
                     state_q   <= S_CMD;
                     armed_q   <= 1'b0;
                     bit_cnt_q <= '0;
                     shift_q   <= '0;
                  end
               end

               S_CMD: if (sclk_rise) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BYTE_BIT) begin
                     cmd_q       <= shift_d[7:0];
                     cmd_valid_q <= 1'b1;
                     bit_cnt_q   <= '0;
                     if (shift_d[7:0] == P_CMD_WRITE || shift_d[7:0] == P_CMD_READ) begin
                        state_q <= S_ADDR;
`ifdef SPI_RESP_WREN_EN
                        wr_txn_q <= (shift_d[7:0] == P_CMD_WRITE);
`endif
                     end else if (shift_d[7:0] == P_CMD_RDSR) begin
                        state_q   <= S_STAT;
                        tx_q      <= status_byte;
                        miso_oe_q <= 1'b1;
`ifdef SPI_RESP_WREN_EN
                     end else if (shift_d[7:0] == CMD_WREN) begin
                        wel_q   <= 1'b1;
                        state_q <= S_IGNORE;
                     end else if (shift_d[7:0] == CMD_WRDI) begin
                        wel_q   <= 1'b0;
                        state_q <= S_IGNORE;
`endif
                     end else begin
                        state_q <= S_IGNORE;
                     end
                  end
               end

               S_ADDR: if (sclk_rise) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_ADDR_BIT) begin
                     bit_cnt_q <= '0;
                     addr_q    <= shift_d;
                     if (cmd_q == P_CMD_READ) begin
                        state_q   <= S_RDATA;
                        rd_req_q  <= 1'b1;
                        miso_oe_q <= 1'b1;
                     end else begin
`ifdef SPI_RESP_WREN_EN
                        state_q <= wel_q ? S_WDATA : S_IGNORE;
`else
                        state_q <= S_WDATA;
`endif
                     end
                  end
               end

               S_WDATA: if (sclk_rise) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BYTE_BIT) begin
                     bit_cnt_q  <= '0;
                     wr_data_q  <= shift_d[7:0];
                     wr_valid_q <= 1'b1;
                  end
               end

               S_RDATA: if (sclk_rise) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BYTE_BIT) begin
                     bit_cnt_q <= '0;
                     rd_req_q  <= 1'b1;
                  end
               end

               S_STAT: if (sclk_rise) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BYTE_BIT) begin
                     bit_cnt_q <= '0;
                     tx_q      <= status_byte;
                  end
               end

               S_IGNORE: begin
               end

               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_spi_miso    = miso_q & miso_oe_q;
   assign bus.o_spi_miso_oe = miso_oe_q;
   assign bus.o_cmd         = cmd_q;
   assign bus.o_cmd_valid   = cmd_valid_q;
   assign bus.o_addr        = addr_q;
   assign bus.o_wr_data     = wr_data_q;
   assign bus.o_wr_valid    = wr_valid_q;
   assign bus.o_rd_req      = rd_req_q;
   assign bus.o_busy        = ~cs_s;
endmodule

// File: tb/tb_spi_flash_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_responder
//   Scoreboard bench: expected commands, writes and read fetches are queued
//   as frames are driven; a negedge monitor pops and compares them when the
//   DUT strobes. MISO bytes are compared inline in each test task.
// ---------------------------------------------------------------------------
module tb_spi_flash_responder;
   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  data;
   } wr_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_flash_responder_if #(.P_ADDR_WIDTH(24)) bus ();

   spi_flash_responder dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;
   int miso_bad = 0;
   int cmd_seen = 0;
   int wr_seen = 0;
   int rd_seen = 0;

   logic [7:0]  cmd_exp[$];
   wr_exp_t     wr_exp[$];
   logic [23:0] rd_exp[$];
   logic        prefetch_ok = 1'b0;
   logic [23:0] prefetch_addr = '0;

   logic [7:0]  tx_bytes[$];
   logic [7:0]  rx_bytes[$];
   logic        oe_any_q[$];
   logic        oe_all_q[$];
   logic        mode3 = 1'b0;
   int          gap_cycles = 16;

   // User-side memory model: byte returned one cycle after the request.
   always @(posedge clk) begin
      if (bus.o_rd_req) bus.i_rd_data <= bus.o_addr[7:0] ^ 8'h5A;
   end

   // Monitor / scoreboard
   logic [7:0]  m_cmd;
   wr_exp_t     m_wr;
   logic [23:0] m_rd;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_cmd_valid) begin
            cmd_seen++;
            checks++;
            $display("cmd   %02h", bus.o_cmd);
            if (cmd_exp.size() == 0) begin
               errors++;
               $display("FAIL cmd_valid: got unexpected cmd %02h, required no strobe", bus.o_cmd);
            end else begin
               m_cmd = cmd_exp.pop_front();
               if (bus.o_cmd !== m_cmd) begin
                  errors++;
                  $display("FAIL cmd: got %02h, required %02h", bus.o_cmd, m_cmd);
               end
            end
         end
         if (bus.o_wr_valid) begin
            wr_seen++;
            checks++;
            $display("write addr=%06h data=%02h", bus.o_addr, bus.o_wr_data);
            if (wr_exp.size() == 0) begin
               errors++;
               $display("FAIL wr_valid: got unexpected write %06h/%02h, required no strobe", bus.o_addr, bus.o_wr_data);
            end else begin
               m_wr = wr_exp.pop_front();
               if ({bus.o_addr, bus.o_wr_data} !== m_wr) begin
                  errors++;
                  $display("FAIL write: got %06h/%02h, required %06h/%02h",
                           bus.o_addr, bus.o_wr_data, m_wr.addr, m_wr.data);
               end
            end
         end
         if (bus.o_rd_req) begin
            rd_seen++;
            checks++;
            $display("rdreq addr=%06h", bus.o_addr);
            if (rd_exp.size() != 0) begin
               m_rd = rd_exp.pop_front();
               if (bus.o_addr !== m_rd) begin
                  errors++;
                  $display("FAIL rd_req addr: got %06h, required %06h", bus.o_addr, m_rd);
               end
            end else if (prefetch_ok && bus.o_addr == prefetch_addr) begin
               prefetch_ok = 1'b0;
            end else begin
               errors++;
               $display("FAIL rd_req: got unexpected fetch at %06h, required no strobe", bus.o_addr);
            end
         end
         if (!bus.o_spi_miso_oe && bus.o_spi_miso !== 1'b0) miso_bad++;
      end
   end

   // Watchdog: every wait is a fixed delay, this only guards the whole run.
   initial begin
      #2ms;
      $display("FAIL watchdog: run time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   task automatic half_bit();
      repeat (8) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic oe_any, output logic oe_all);
      rx = '0;
      oe_any = 1'b0;
      oe_all = 1'b1;
      for (int i = 7; i >= 8 - nbits; i--) begin
         if (mode3) bus.i_spi_clk = 1'b0;
         bus.i_spi_mosi = tx[i];
         half_bit();
         rx = {rx[6:0], bus.o_spi_miso};
         oe_any = oe_any | bus.o_spi_miso_oe;
         oe_all = oe_all & bus.o_spi_miso_oe;
         bus.i_spi_clk = 1'b1;
         half_bit();
         if (!mode3) bus.i_spi_clk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      bus.i_spi_clk = mode3;
      repeat (8) @(negedge clk);
      bus.i_spi_cs = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (8) @(negedge clk);
      bus.i_spi_cs = 1'b1;
      repeat (gap_cycles) @(negedge clk);
   endtask

   task automatic send_bytes();
      logic [7:0] rx;
      logic a, b;
      rx_bytes.delete();
      oe_any_q.delete();
      oe_all_q.delete();
      foreach (tx_bytes[k]) begin
         spi_bits(tx_bytes[k], 8, rx, a, b);
         rx_bytes.push_back(rx);
         oe_any_q.push_back(a);
         oe_all_q.push_back(b);
      end
   endtask

   task automatic xfer();
      cs_begin();
      send_bytes();
      cs_end();
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (cmd_exp.size() != 0 || wr_exp.size() != 0 || rd_exp.size() != 0) begin
         errors++;
         $display("FAIL %s drained: got pending cmd=%0d wr=%0d rd=%0d, required 0/0/0",
                  name, cmd_exp.size(), wr_exp.size(), rd_exp.size());
      end
      cmd_exp.delete();
      wr_exp.delete();
      rd_exp.delete();
   endtask

   task automatic test_reset();
      bus.i_spi_cs = 1'b1;
      bus.i_spi_clk = 1'b0;
      bus.i_spi_mosi = 1'b0;
      bus.i_status = 8'h00;
      bus.i_rd_data = 8'h00;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({bus.o_spi_miso, bus.o_spi_miso_oe, bus.o_cmd, bus.o_cmd_valid, bus.o_addr,
           bus.o_wr_data, bus.o_wr_valid, bus.o_rd_req, bus.o_busy} !== '0) begin
         errors++;
         $display("FAIL reset outputs: got nonzero output, required all 0");
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset busy: got %b, required 0", bus.o_busy);
      end
   endtask

   task automatic test_cs_low_at_reset();
      int c0;
      logic [7:0] rx;
      logic a, b;
      c0 = cmd_seen;
      rst_n = 1'b0;
      bus.i_spi_cs = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL cs_low busy: got %b, required 1", bus.o_busy);
      end
      spi_bits(8'h9F, 8, rx, a, b);
      cs_end();
      checks++;
      if (cmd_seen != c0 || a !== 1'b0) begin
         errors++;
         $display("FAIL cs_low_at_reset: got cmd strobes=%0d oe=%b, required 0/0", cmd_seen - c0, a);
      end
   endtask

   task automatic test_write();
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h0012FE, 8'hAA});
      wr_exp.push_back({24'h0012FF, 8'h55});
      tx_bytes = '{8'h02, 8'h00, 8'h12, 8'hFE, 8'hAA, 8'h55};
      xfer();
      check_drained("write");
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL write busy after cs: got %b, required 0", bus.o_busy);
      end
   endtask

   task automatic test_page_wrap();
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h0012FF, 8'h11});
      wr_exp.push_back({24'h001200, 8'h22});
      wr_exp.push_back({24'h001201, 8'h33});
      tx_bytes = '{8'h02, 8'h00, 8'h12, 8'hFF, 8'h11, 8'h22, 8'h33};
      xfer();
      check_drained("page_wrap");
   endtask

   task automatic test_read();
      cmd_exp.push_back(8'h03);
      rd_exp.push_back(24'h000010);
      rd_exp.push_back(24'h000011);
      prefetch_ok = 1'b1;
      prefetch_addr = 24'h000012;
      tx_bytes = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      xfer();
      prefetch_ok = 1'b0;
      check_drained("read");
      checks++;
      if (rx_bytes[4] !== 8'h4A || rx_bytes[5] !== 8'h4B) begin
         errors++;
         $display("FAIL read miso: got %02h %02h, required 4a 4b", rx_bytes[4], rx_bytes[5]);
      end
      checks++;
      if ((oe_any_q[0] | oe_any_q[1] | oe_any_q[2] | oe_any_q[3]) !== 1'b0) begin
         errors++;
         $display("FAIL read oe header: got oe high in header, required low");
      end
      checks++;
      if ((oe_all_q[4] & oe_all_q[5]) !== 1'b1) begin
         errors++;
         $display("FAIL read oe data: got oe low in data phase, required high");
      end
      checks++;
      if (bus.o_spi_miso_oe !== 1'b0) begin
         errors++;
         $display("FAIL read oe after cs: got %b, required 0", bus.o_spi_miso_oe);
      end
   endtask

   task automatic test_status();
      int r0;
      r0 = rd_seen;
      mode3 = 1'b1;
      bus.i_status = 8'h81;
      cmd_exp.push_back(8'h05);
      tx_bytes = '{8'h05, 8'h00, 8'h00};
      xfer();
      mode3 = 1'b0;
      check_drained("status");
      checks++;
      if (rx_bytes[1] !== 8'h81 || rx_bytes[2] !== 8'h81) begin
         errors++;
         $display("FAIL status miso: got %02h %02h, required 81 81", rx_bytes[1], rx_bytes[2]);
      end
      checks++;
      if (rd_seen != r0 || oe_any_q[0] !== 1'b0 || oe_all_q[1] !== 1'b1) begin
         errors++;
         $display("FAIL status phase: got rd_req=%0d oe_cmd=%b oe_data=%b, required 0/0/1",
                  rd_seen - r0, oe_any_q[0], oe_all_q[1]);
      end
   endtask

   task automatic test_abort();
      int w0;
      logic [7:0] rx;
      logic a, b;
      w0 = wr_seen;
      cmd_exp.push_back(8'h02);
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00};
      cs_begin();
      send_bytes();
      spi_bits(8'hFF, 5, rx, a, b);
      cs_end();
      checks++;
      if (wr_seen != w0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort: got writes=%0d busy=%b, required 0/0", wr_seen - w0, bus.o_busy);
      end
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h000040, 8'hC3});
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h40, 8'hC3};
      xfer();
      check_drained("abort_follow");
   endtask

   task automatic test_unknown();
      int w0, r0;
      w0 = wr_seen;
      r0 = rd_seen;
      cmd_exp.push_back(8'h9F);
      tx_bytes = '{8'h9F, 8'h12, 8'h34};
      xfer();
      check_drained("unknown");
      checks++;
      if (wr_seen != w0 || rd_seen != r0 ||
          (oe_any_q[0] | oe_any_q[1] | oe_any_q[2]) !== 1'b0) begin
         errors++;
         $display("FAIL unknown: got writes=%0d reads=%0d oe_seen=%b, required 0/0/0",
                  wr_seen - w0, rd_seen - r0, oe_any_q[0] | oe_any_q[1] | oe_any_q[2]);
      end
   endtask

   task automatic test_wren();
      int w0;
      w0 = wr_seen;
`ifdef SPI_RESP_WREN_EN
      cmd_exp.push_back(8'h02);
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hA5};
      xfer();
      cmd_exp.push_back(8'h06);
      tx_bytes = '{8'h06};
      xfer();
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h000000, 8'hA5});
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hA5};
      xfer();
      cmd_exp.push_back(8'h02);
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h5A};
      xfer();
`else
      cmd_exp.push_back(8'h06);
      tx_bytes = '{8'h06, 8'hAA};
      xfer();
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h000000, 8'hA5});
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hA5};
      xfer();
`endif
      check_drained("wren");
      checks++;
      if (wr_seen - w0 != 1) begin
         errors++;
         $display("FAIL wren writes: got %0d, required 1", wr_seen - w0);
      end
   endtask

   task automatic test_mid_reset();
      int w0;
      logic [7:0] rx;
      logic a, b;
      w0 = wr_seen;
      cmd_exp.push_back(8'h02);
      tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00};
      cs_begin();
      send_bytes();
      spi_bits(8'hF0, 4, rx, a, b);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.o_spi_miso_oe, bus.o_cmd, bus.o_addr, bus.o_wr_valid, bus.o_busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset outputs: got nonzero output, required all 0");
      end
      rst_n = 1'b1;
      spi_bits(8'hAB, 8, rx, a, b);
      spi_bits(8'hCD, 8, rx, a, b);
      cs_end();
      check_drained("mid_reset");
      checks++;
      if (wr_seen != w0) begin
         errors++;
         $display("FAIL mid_reset writes: got %0d, required 0", wr_seen - w0);
      end
   endtask

   task automatic test_back_to_back();
      gap_cycles = 6;
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h003456, 8'h11});
      tx_bytes = '{8'h02, 8'h00, 8'h34, 8'h56, 8'h11};
      xfer();
      cmd_exp.push_back(8'h02);
      wr_exp.push_back({24'h00AB00, 8'h22});
      tx_bytes = '{8'h02, 8'h00, 8'hAB, 8'h00, 8'h22};
      xfer();
      gap_cycles = 16;
      repeat (10) @(negedge clk);
      check_drained("back_to_back");
   endtask

   initial begin
      test_reset();
      test_cs_low_at_reset();
      test_write();
      test_page_wrap();
      test_read();
      test_status();
      test_abort();
      test_unknown();
      test_wren();
      test_mid_reset();
      test_back_to_back();
      checks++;
      if (miso_bad != 0) begin
         errors++;
         $display("FAIL miso idle: got %0d cycles driven while disabled, required 0", miso_bad);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
